// File: rtl/ifetch_if.sv
// Fetch-queue bus: instruction memory request/response, redirect and decode handshake.
// The master modport is the fetch queue; the slave modport is memory/decode/hazard logic.
interface ifetch_if #(
   parameter int unsigned DEPTH = 4
);
   logic                         imem_req;
   logic [31:0]                  imem_addr;
   logic [31:0]                  imem_rdata;
   logic                         redirect_valid;
   logic [31:0]                  redirect_pc;
   logic                         dec_ready;
   logic                         dec_valid;
   logic [31:0]                  dec_instr;
   logic [31:0]                  dec_pc;
   logic [$clog2(DEPTH+1)-1:0]   q_count;

   modport master (
      output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, q_count,
      input  imem_rdata, redirect_valid, redirect_pc, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, q_count,
      output imem_rdata, redirect_valid, redirect_pc, dec_ready
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: sequential fetch into a fixed-latency imem, buffered bundles
// presented to decode, full flush and restart on redirect.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic      clk,
   input logic      reset,
   ifetch_if.master bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   instr_mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [CW:0]   occupancy;
   logic          issue;
   logic          push;
   logic          pop;

   always_comb begin
      // The in-flight request reserves a slot, so a push never finds the FIFO full.
      occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      issue     = !reset && !bus.redirect_valid && (occupancy < (CW+1)'(DEPTH));
      push      = inflight_q && !bus.redirect_valid;
      pop       = (count_q != '0) && bus.dec_ready && !bus.redirect_valid;

      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      pc_mem_d      = pc_mem_q;
      instr_mem_d   = instr_mem_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         if (push) begin
            pc_mem_d[wr_ptr_q]    = inflight_pc_q;
            instr_mem_d[wr_ptr_q] = bus.imem_rdata;
            wr_ptr_d              = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         pc_mem_q      <= pc_mem_d;
         instr_mem_q   <= instr_mem_d;
      end
   end

   assign bus.imem_req  = issue;
   assign bus.imem_addr = fetch_pc_q;
   assign bus.dec_valid = (count_q != '0);
   assign bus.dec_instr = instr_mem_q[rd_ptr_q];
   assign bus.dec_pc    = pc_mem_q[rd_ptr_q];
   assign bus.q_count   = count_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a one-cycle instruction memory plus a queue-based model of
// the fetch buffer, driven by directed scenarios and a randomized stream.
module tb_ifetch_queue;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ifetch_if #(.DEPTH(DEPTH)) bus ();

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: queue of bundles, next fetch address, and one outstanding request.
   logic [31:0] mq_pc[$];
   logic [31:0] mq_in[$];
   logic [31:0] m_fetch;
   logic [31:0] m_pend_pc;
   bit          m_pend;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   function automatic bit m_req();
      return !rst && !bus.redirect_valid && ((mq_pc.size() + int'(m_pend)) < int'(DEPTH));
   endfunction

   // Advance model and memory by one clock; called at the negedge after checks.
   task automatic step();
      logic        r;
      logic [31:0] a;
      bit          mr;
      r  = bus.imem_req;
      a  = bus.imem_addr;
      mr = m_req();
      if (rst) begin
         mq_pc.delete(); mq_in.delete();
         m_pend  = 0;
         m_fetch = RESET_PC;
      end else if (bus.redirect_valid) begin
         mq_pc.delete(); mq_in.delete();
         m_pend  = 0;
         m_fetch = bus.redirect_pc;
      end else begin
         if (mq_pc.size() != 0 && bus.dec_ready) begin
            void'(mq_pc.pop_front());
            void'(mq_in.pop_front());
         end
         if (m_pend) begin
            mq_pc.push_back(m_pend_pc);
            mq_in.push_back(word(m_pend_pc));
         end
         if (mr) begin
            m_pend    = 1;
            m_pend_pc = m_fetch;
            m_fetch   = m_fetch + 32'd4;
         end else begin
            m_pend = 0;
         end
      end
      @(posedge clk);
      #1;
      bus.imem_rdata = r ? word(a) : $urandom();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.dec_ready      = 1'b0;
      @(negedge clk); step();
      @(negedge clk); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.dec_ready      = 1'b1;
      @(negedge clk); step();
      @(negedge clk);
      checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b want 0", bus.dec_valid); end
      checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL reset_q_count got %0d want 0", bus.q_count); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %b want 0", bus.imem_req); end
      checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_imem_addr got %h want %h", bus.imem_addr, RESET_PC); end
      checks++; if (bus.dec_pc !== 32'd0 || bus.dec_instr !== 32'd0) begin
         errors++; $display("FAIL reset_entries got pc=%h instr=%h want 0", bus.dec_pc, bus.dec_instr);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_stream();
      bus.dec_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++; if (bus.imem_req !== m_req()) begin errors++; $display("FAIL stream_req c%0d got %b want %b", k, bus.imem_req, m_req()); end
         checks++; if (bus.imem_addr !== m_fetch) begin errors++; $display("FAIL stream_addr c%0d got %h want %h", k, bus.imem_addr, m_fetch); end
         checks++; if (bus.q_count !== mq_pc.size()) begin errors++; $display("FAIL stream_count c%0d got %0d want %0d", k, bus.q_count, mq_pc.size()); end
         checks++; if (bus.dec_valid !== (mq_pc.size() != 0)) begin errors++; $display("FAIL stream_valid c%0d got %b", k, bus.dec_valid); end
         if (mq_pc.size() != 0) begin
            checks++; if (bus.dec_pc !== mq_pc[0] || bus.dec_instr !== mq_in[0]) begin
               errors++; $display("FAIL stream_head c%0d got %h/%h want %h/%h", k, bus.dec_pc, bus.dec_instr, mq_pc[0], mq_in[0]);
            end
         end
         if (k == 1) begin
            checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got dec_valid=%b want 0 at cycle 1", bus.dec_valid); end
         end
         if (k >= 2) begin
            checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== RESET_PC + 32'(4*(k-2))) begin
               errors++; $display("FAIL stream_seq c%0d got %b/%h want 1/%h", k, bus.dec_valid, bus.dec_pc, RESET_PC + 32'(4*(k-2)));
            end
         end
         step();
      end
   endtask

   task automatic test_stall_full();
      reset_dut();
      bus.dec_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++; if (bus.imem_req !== m_req() || bus.imem_addr !== m_fetch) begin
            errors++; $display("FAIL stall_req c%0d got %b/%h want %b/%h", k, bus.imem_req, bus.imem_addr, m_req(), m_fetch);
         end
         checks++; if (bus.q_count !== mq_pc.size()) begin errors++; $display("FAIL stall_count c%0d got %0d want %0d", k, bus.q_count, mq_pc.size()); end
         if (k < 7) step();
      end
      checks++; if (bus.q_count !== 3'd4 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL full_state got count=%0d req=%b want 4/0", bus.q_count, bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h10 || bus.dec_pc !== 32'h0) begin errors++; $display("FAIL full_hold got addr=%h pc=%h want 10/0", bus.imem_addr, bus.dec_pc); end
      step();
      bus.dec_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 4) begin
            checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'(4*k) || bus.dec_instr !== word(32'(4*k))) begin
               errors++; $display("FAIL drain_head c%0d got %b/%h/%h want pc %h", k, bus.dec_valid, bus.dec_pc, bus.dec_instr, 32'(4*k));
            end
         end
         if (k == 0) begin
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL drain_no_credit got req=%b want 0", bus.imem_req); end
         end
         if (k == 1) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
               errors++; $display("FAIL drain_resume got %b/%h want 1/00000010", bus.imem_req, bus.imem_addr);
            end
         end
         step();
      end
   endtask

   task automatic test_redirect();
      reset_dut();
      bus.dec_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin @(negedge clk); step(); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_blocked got %b want 0", bus.imem_req); end
      step();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.dec_valid !== 1'b0 || bus.q_count !== 3'd0) begin errors++; $display("FAIL redir_flush got %b/%0d want 0/0", bus.dec_valid, bus.q_count); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_fetch got %b/%h want 1/00000100", bus.imem_req, bus.imem_addr); end
      step();
      @(negedge clk);
      checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL redir_stale got dec_valid=%b pc=%h want 0", bus.dec_valid, bus.dec_pc); end
      step();
      @(negedge clk);
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h100 || bus.dec_instr !== word(32'h100)) begin
         errors++; $display("FAIL redir_first got %b/%h/%h want 1/00000100/%h", bus.dec_valid, bus.dec_pc, bus.dec_instr, word(32'h100));
      end
      step();
   endtask

   task automatic test_push_pop();
      reset_dut();
      bus.dec_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin @(negedge clk); step(); end
      bus.dec_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.q_count !== 3'd2 || bus.dec_pc !== 32'h0) begin errors++; $display("FAIL pp_setup got %0d/%h want 2/00000000", bus.q_count, bus.dec_pc); end
      step();
      @(negedge clk);
      checks++; if (bus.q_count !== 3'd2 || bus.dec_pc !== 32'h4 || bus.dec_instr !== word(32'h4)) begin
         errors++; $display("FAIL pp_both got %0d/%h/%h want 2/00000004", bus.q_count, bus.dec_pc, bus.dec_instr);
      end
      step();
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'hFFFF_FFF8;
      exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000;
      bus.dec_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFF8;
      @(negedge clk); step();
      bus.redirect_valid = 1'b0;
      @(negedge clk); step();
      @(negedge clk); step();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== exp_pc[k] || bus.dec_instr !== word(exp_pc[k])) begin
            errors++; $display("FAIL wrap_seq %0d got %b/%h/%h want 1/%h", k, bus.dec_valid, bus.dec_pc, bus.dec_instr, exp_pc[k]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      bus.dec_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin @(negedge clk); step(); end
      rst                = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      @(negedge clk);
      checks++; if (bus.q_count !== 3'd3) begin errors++; $display("FAIL rmid_setup got %0d want 3", bus.q_count); end
      step();
      rst                = 1'b0;
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.dec_valid !== 1'b0 || bus.q_count !== 3'd0) begin errors++; $display("FAIL rmid_clear got %b/%0d want 0/0", bus.dec_valid, bus.q_count); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rmid_fetch got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RESET_PC); end
      step();
      @(negedge clk);
      checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rmid_drop got dec_valid=%b want 0", bus.dec_valid); end
      step();
      @(negedge clk);
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== RESET_PC) begin errors++; $display("FAIL rmid_restart got %b/%h want 1/%h", bus.dec_valid, bus.dec_pc, RESET_PC); end
      step();
   endtask

   task automatic test_random();
      logic [31:0] rpc;
      reset_dut();
      for (int k = 0; k < 400; k++) begin
         rpc                = $urandom() & 32'hFFFF_FFFC;
         bus.dec_ready      = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = ($urandom_range(0, 24) == 0);
         bus.redirect_pc    = rpc;
         rst                = ($urandom_range(0, 79) == 0);
         @(negedge clk);
         checks++; if (bus.imem_req !== m_req()) begin errors++; $display("FAIL rand_req c%0d got %b want %b", k, bus.imem_req, m_req()); end
         checks++; if (bus.imem_addr !== m_fetch) begin errors++; $display("FAIL rand_addr c%0d got %h want %h", k, bus.imem_addr, m_fetch); end
         checks++; if (bus.q_count !== mq_pc.size()) begin errors++; $display("FAIL rand_count c%0d got %0d want %0d", k, bus.q_count, mq_pc.size()); end
         checks++; if (bus.dec_valid !== (mq_pc.size() != 0)) begin errors++; $display("FAIL rand_valid c%0d got %b", k, bus.dec_valid); end
         if (mq_pc.size() != 0) begin
            checks++; if (bus.dec_pc !== mq_pc[0] || bus.dec_instr !== mq_in[0]) begin
               errors++; $display("FAIL rand_head c%0d got %h/%h want %h/%h", k, bus.dec_pc, bus.dec_instr, mq_pc[0], mq_in[0]);
            end
         end
         step();
      end
      rst                = 1'b0;
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      rst                = 1'b1;
      bus.imem_rdata     = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.dec_ready      = 1'b0;
      m_fetch            = RESET_PC;
      m_pend             = 0;
      m_pend_pc          = '0;
      #1;
      test_reset();
      test_stream();
      test_stall_full();
      test_redirect();
      test_push_pop();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue that sits between the instruction memory and the IF/ID pipeline register. It generates sequential fetch addresses, issues requests to a fixed-latency instruction memory and buffers the returned bundles in a small FIFO. It presents one 32-bit bundle plus its PC per cycle to decode, and holds that bundle while decode stalls (hazard unit drives IF/ID write low). On a redirect (branch, jump or exception) it flushes all buffered and in-flight bundles and restarts fetch at the new PC.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request this cycle (combinational from state).
- imem_addr  out  32  fetch address; equals internal fetch_pc.
- imem_rdata  in  32  instruction data, valid the cycle after a cycle with imem_req=1.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  restart address, sampled when redirect_valid=1.
- dec_ready  in  1  decode accepts the bundle (IF/ID write enable).
- dec_valid  out  1  queue head is valid.
- dec_instr  out  32  head instruction bundle.
- dec_pc  out  32  PC of the head bundle.
- q_count  out  $clog2(DEPTH+1)  current number of occupied entries.

## Operation
- State: fetch_pc (32), inflight flag (1), inflight_pc (32), FIFO of DEPTH entries {pc, instr} with read pointer, write pointer and count.
- Issue rule: imem_req = !reset && !redirect_valid && (count + inflight) < DEPTH. The check is conservative and does not credit a same-cycle pop.
- On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4. Addition is modulo 2^32 and wraps from 32'hFFFF_FFFC to 0.
- No issue: inflight <= 0.
- Push: in a cycle with inflight=1 and no redirect, write {inflight_pc, imem_rdata} at the write pointer. Space is guaranteed by the issue rule.
- Pop: dec_valid && dec_ready && !redirect_valid. Advances the read pointer.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- dec_valid = (count != 0). dec_instr and dec_pc always show the head entry and hold stable while dec_ready=0.
- Redirect (redirect_valid=1, reset=0):
  - count <= 0, pointers <= 0, inflight <= 0; any push or pop in that cycle is discarded.
  - The response arriving the next cycle belongs to a request from before the redirect, so it is not pushed because inflight is 0.
  - fetch_pc <= redirect_pc; the first request at redirect_pc goes out the following cycle.
- Reset has priority over redirect.

## Timing
- Reset values: dec_valid=0, q_count=0, imem_req=0, imem_addr=RESET_PC. dec_instr and dec_pc are don't-care while dec_valid=0; they read 0 after reset (entries are cleared).
- Cycle 0 is the first cycle with reset low: imem_req=1, imem_addr=RESET_PC.
- Cycle 1: imem_rdata carries the cycle-0 bundle and is captured at the end of cycle 1.
- Cycle 2: dec_valid=1, dec_pc=RESET_PC.
- Request-to-decode latency is 2 cycles. Steady-state throughput is 1 bundle/cycle with dec_ready=1.
- Redirect in cycle t: dec_valid=0 in t+1, request at redirect_pc in t+1, first new bundle valid in t+3.
- Full condition: count + inflight == DEPTH, which forces imem_req=0. Fetch resumes in the cycle after the first pop.
- Reset asserted mid-operation: all state returns to reset values at the next edge, and the in-flight response is dropped.

## Test plan
- Reset and stream:
  - Stimulus: RESET_PC=0, dec_ready=1, imem_rdata=addr^32'hA5A5_0000.
  - Response: dec_valid rises 2 cycles after reset release; dec_pc shows 0, 4, 8, … with one bundle per cycle; dec_instr matches each PC.
- Stall to full:
  - Stimulus: dec_ready=0 from reset.
  - Response: q_count climbs to 4 and imem_req drops; fetch addresses stop at 0x10; the head holds pc=0.
  - Then set dec_ready=1: bundles 0, 4, 8, C are consumed in order, and fetch resumes at 0x10 in the cycle after the first pop.
- Redirect with in-flight request:
  - Stimulus: streaming, then redirect_valid=1 with redirect_pc=0x100 while inflight=1.
  - Response: the next cycle shows dec_valid=0, q_count=0 and a request at 0x100. The stale response is not enqueued. dec_pc=0x100 appears 3 cycles after the redirect.
- Simultaneous push and pop:
  - Stimulus: count=2, dec_ready=1, with a response arriving.
  - Response: q_count stays at 2 and the head advances by 4.
- PC wrap:
  - Stimulus: redirect_pc=32'hFFFF_FFF8.
  - Response: dec_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset mid-operation:
  - Stimulus: queue at 3 entries, reset pulsed high for 1 cycle together with redirect_valid=1.
  - Response: state matches the post-reset values; fetch restarts at RESET_PC, not at redirect_pc.
